rr_packet_arbiter: RTL

Sequential round-robin arbiter for one output port of the simple_mesh_xy switch. It is a drop-in successor to the combinational fixed-priority input selector. It grants the output to one input per packet and holds that grant (wormhole lock) until the tail flit transfers. It drives the output mux select, pops the granted input buffer, and qualifies the output valid against downstream ready.

---
 rtl/noc_switch_pkg.sv | 20 ++
 rtl/rr_pick.sv | 33 +++
 rtl/rr_packet_arbiter.sv | 101 ++++++++++
 3 files changed

// File: rtl/noc_switch_pkg.sv
// Shared definitions for the simple_mesh_xy switch: port indices,
// arbiter state encoding and the mux-select width helper.
package noc_switch_pkg;

    localparam int LOCAL = 0;
    localparam int N     = 1;
    localparam int E     = 2;
    localparam int S     = 3;
    localparam int W     = 4;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder.
// req: request vector; ptr: last winner (search starts at ptr+1);
// idx: chosen index; any: at least one request present.
module rr_pick
    import noc_switch_pkg::*;
#(
    parameter int  PORT_N = 5,
    localparam int SEL_W  = sel_w(PORT_N)
) (
    input  logic [PORT_N-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  idx,
    output logic              any
);

    int j;

    // Scan ptr+1 .. ptr+PORT_N modulo PORT_N; the modulo keeps every
    // candidate index below PORT_N even when ptr sits at the top.
    always_comb begin
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 1; k <= PORT_N; k++) begin
            j = (int'(ptr) + k) % PORT_N;
            if (!any && req[j]) begin
                any = 1'b1;
                idx = SEL_W'(j);
            end
        end
    end

endmodule

// File: rtl/rr_packet_arbiter.sv
// Round-robin wormhole arbiter for one switch output port.
// Ports: clk_i/rst_ni (sync, active-low); vld_i/head_i/tail_i per input;
// out_rdy_i from downstream; mux_in_sel_o, out_vld_o, rd_en_o, busy_o, err_o.
module rr_packet_arbiter
    import noc_switch_pkg::*;
#(
    parameter int  PORT_N = 5,
    localparam int SEL_W  = sel_w(PORT_N)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [PORT_N-1:0] vld_i,
    input  logic [PORT_N-1:0] head_i,
    input  logic [PORT_N-1:0] tail_i,
    input  logic              out_rdy_i,
    output logic [SEL_W-1:0]  mux_in_sel_o,
    output logic              out_vld_o,
    output logic [PORT_N-1:0] rd_en_o,
    output logic              busy_o,
    output logic              err_o
);

    if (PORT_N < 3 || PORT_N > 5) begin : g_bad_port_n
        $error("rr_packet_arbiter: PORT_N must be 3, 4 or 5");
    end

    arb_state_e       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             first_q, first_d;
    logic             err_q, err_d;
    logic             xfer;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_any;

    rr_pick #(
        .PORT_N (PORT_N)
    ) u_pick (
        .req (vld_i & head_i),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ARB_IDLE;
            sel_q   <= '0;
            ptr_q   <= SEL_W'(PORT_N - 1);
            first_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            first_q <= first_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        first_d   = first_q;
        err_d     = err_q;
        xfer      = 1'b0;
        out_vld_o = 1'b0;
        rd_en_o   = '0;
        unique case (state_q)
            ARB_IDLE: begin
                // A body flit at the front of an idle input is a broken packet.
                if (|(vld_i & ~head_i)) err_d = 1'b1;
                if (pick_any) begin
                    sel_d   = pick_idx;
                    first_d = 1'b1;
                    state_d = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                out_vld_o = vld_i[sel_q];
                xfer      = vld_i[sel_q] & out_rdy_i;
                if (xfer) begin
                    rd_en_o = PORT_N'(1) << sel_q;
                    first_d = 1'b0;
                    if (head_i[sel_q] && !first_q) err_d = 1'b1;
                    if (tail_i[sel_q]) begin
                        state_d = ARB_IDLE;
                        ptr_d   = sel_q;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign mux_in_sel_o = sel_q;
    assign busy_o       = (state_q == ARB_LOCKED);
    assign err_o        = err_q;

endmodule
